// File: rtl/arb_pkg.sv
// Shared types for the four-way round-robin arbiter.
package arb_pkg;
    localparam int NREQ = 4;
    typedef logic [1:0] req_idx_t;
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
endpackage

// File: rtl/mux4.sv
// Four-input SIZE-bit multiplexer used on the arbiter datapath.
module mux4 #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] d0,
    input  logic [SIZE-1:0] d1,
    input  logic [SIZE-1:0] d2,
    input  logic [SIZE-1:0] d3,
    input  logic [1:0]      s,
    output logic [SIZE-1:0] y
);
    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set bit of req starting at ptr, wrapping.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  req_idx_t        ptr,
    output logic            found,
    output req_idx_t        idx
);
    req_idx_t cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Scan farthest first so the candidate closest to ptr overwrites the rest.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + req_idx_t'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with burst locking and a registered output stage.
module arb4_rr
    import arb_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_last,
    input  logic [SIZE-1:0] req_data0,
    input  logic [SIZE-1:0] req_data1,
    input  logic [SIZE-1:0] req_data2,
    input  logic [SIZE-1:0] req_data3,
    output logic [NREQ-1:0] req_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    output logic [1:0]      out_src,
    output logic            out_last,
    input  logic            out_ready
);
    lock_state_t     state_q, state_d;
    req_idx_t        owner_q, owner_d;
    req_idx_t        ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [SIZE-1:0] out_data_q, out_data_d;
    req_idx_t        out_src_q, out_src_d;
    logic            out_last_q, out_last_d;

    logic            pick_found;
    req_idx_t        pick_idx;
    logic            win_found;
    req_idx_t        win_idx;
    logic            accept_en;
    logic            accept;
    logic [SIZE-1:0] mux_y;

    rr_pick4 u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    mux4 #(.SIZE(SIZE)) u_mux (
        .d0 (req_data0),
        .d1 (req_data1),
        .d2 (req_data2),
        .d3 (req_data3),
        .s  (win_idx),
        .y  (mux_y)
    );

    // While locked only the owner may win; no fallback to the picker.
    always_comb begin
        win_found = pick_found;
        win_idx   = pick_idx;
        if (state_q == LOCKED) begin
            win_found = req_valid[owner_q];
            win_idx   = owner_q;
        end
        accept_en = !reset && (!out_valid_q || out_ready);
        req_ready = '0;
        if (accept_en && win_found) req_ready[win_idx] = 1'b1;
        accept    = |req_ready;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_y;
            out_src_d   = win_idx;
            out_last_d  = req_last[win_idx];
            if (req_last[win_idx]) begin
                state_d = UNLOCKED;
                ptr_d   = win_idx + 2'd1;
            end else begin
                state_d = LOCKED;
                owner_d = win_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= UNLOCKED;
            owner_q     <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_arb4_rr.sv
// Directed vector bench for arb4_rr: each row drives inputs after the falling edge
// and checks req_ready plus the registered outputs left by the previous rising edge.
module tb_arb4_rr;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid, req_last, req_ready;
    logic [7:0] d0, d1, d2, d3;
    logic       out_valid, out_last, out_ready;
    logic [7:0] out_data;
    logic [1:0] out_src;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    arb4_rr #(.SIZE(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data0 (d0),
        .req_data1 (d1),
        .req_data2 (d2),
        .req_data3 (d3),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] l;
        logic [7:0] a0, a1, a2, a3;
        logic       ordy;
        logic [3:0] e_rr;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_os;
        logic       e_ol;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int row, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    endtask

    task automatic step(input int row, input vec_t t);
        @(negedge clk);
        reset     = t.rst;
        req_valid = t.v;
        req_last  = t.l;
        d0 = t.a0; d1 = t.a1; d2 = t.a2; d3 = t.a3;
        out_ready = t.ordy;
        #1;
        chk("req_ready", row, int'(req_ready), int'(t.e_rr));
        chk("out_valid", row, int'(out_valid), int'(t.e_ov));
        chk("out_data",  row, int'(out_data),  int'(t.e_od));
        chk("out_src",   row, int'(out_src),   int'(t.e_os));
        chk("out_last",  row, int'(out_last),  int'(t.e_ol));
    endtask

    function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] l,
                                logic [7:0] a0, logic [7:0] a1, logic [7:0] a2, logic [7:0] a3,
                                logic ordy, logic [3:0] e_rr, logic e_ov, logic [7:0] e_od,
                                logic [1:0] e_os, logic e_ol);
        vec_t t;
        t.rst = rst; t.v = v; t.l = l;
        t.a0 = a0; t.a1 = a1; t.a2 = a2; t.a3 = a3;
        t.ordy = ordy; t.e_rr = e_rr; t.e_ov = e_ov;
        t.e_od = e_od; t.e_os = e_os; t.e_ol = e_ol;
        return t;
    endfunction

    initial begin
        // Burst of four all-last requests, rotating 0..3, one beat per cycle.
        tbl[0]  = mk(1, 4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0000, 0, 8'h00, 0, 0);
        tbl[1]  = mk(0, 4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0001, 0, 8'h00, 0, 0);
        tbl[2]  = mk(0, 4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0010, 1, 8'h10, 0, 1);
        tbl[3]  = mk(0, 4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0100, 1, 8'h11, 1, 1);
        tbl[4]  = mk(0, 4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b1000, 1, 8'h12, 2, 1);
        // Drain, then backpressure: single accept into empty stage, then hold.
        tbl[5]  = mk(0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 1, 8'h13, 3, 1);
        tbl[6]  = mk(0, 4'b0001, 4'b0001, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 4'b0001, 0, 8'h13, 3, 1);
        tbl[7]  = mk(0, 4'b0001, 4'b0001, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 4'b0000, 1, 8'hA5, 0, 1);
        tbl[8]  = mk(0, 4'b0001, 4'b0001, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 4'b0000, 1, 8'hA5, 0, 1);
        tbl[9]  = mk(0, 4'b0001, 4'b0001, 8'hA6, 8'h00, 8'h00, 8'h00, 1, 4'b0001, 1, 8'hA5, 0, 1);
        // req1 burst 21,22,23 locks out req2.
        tbl[10] = mk(0, 4'b0110, 4'b0100, 8'h00, 8'h21, 8'h30, 8'h00, 1, 4'b0010, 1, 8'hA6, 0, 1);
        tbl[11] = mk(0, 4'b0110, 4'b0100, 8'h00, 8'h22, 8'h30, 8'h00, 1, 4'b0010, 1, 8'h21, 1, 0);
        tbl[12] = mk(0, 4'b0110, 4'b0110, 8'h00, 8'h23, 8'h30, 8'h00, 1, 4'b0010, 1, 8'h22, 1, 0);
        tbl[13] = mk(0, 4'b0100, 4'b0100, 8'h00, 8'h00, 8'h30, 8'h00, 1, 4'b0100, 1, 8'h23, 1, 1);
        // ptr=3 after req2: 3 beats 0, then ptr wraps to 1 so 1 beats 0.
        tbl[14] = mk(0, 4'b1001, 4'b1001, 8'h40, 8'h00, 8'h00, 8'h43, 1, 4'b1000, 1, 8'h30, 2, 1);
        tbl[15] = mk(0, 4'b1001, 4'b1001, 8'h40, 8'h00, 8'h00, 8'h43, 1, 4'b0001, 1, 8'h43, 3, 1);
        tbl[16] = mk(0, 4'b0011, 4'b0011, 8'h40, 8'h41, 8'h00, 8'h00, 1, 4'b0010, 1, 8'h40, 0, 1);
        tbl[17] = mk(0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 1, 8'h41, 1, 1);
        tbl[18] = mk(0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 0, 8'h41, 1, 1);

        reset = 1'b1; req_valid = '0; req_last = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 19; i++) step(i, tbl[i]);

        // Owner stall: req1 locks, goes idle; req0 waits until req1 sends last. ptr=2 here.
        step(100, mk(0, 4'b0010, 4'b0000, 8'h50, 8'h21, 8'h00, 8'h00, 1, 4'b0010, 0, 8'h41, 1, 1));
        step(101, mk(0, 4'b0001, 4'b0001, 8'h50, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 1, 8'h21, 1, 0));
        step(102, mk(0, 4'b0001, 4'b0001, 8'h50, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 0, 8'h21, 1, 0));
        step(103, mk(0, 4'b0011, 4'b0011, 8'h50, 8'h2F, 8'h00, 8'h00, 1, 4'b0010, 0, 8'h21, 1, 0));
        step(104, mk(0, 4'b0001, 4'b0001, 8'h50, 8'h00, 8'h00, 8'h00, 1, 4'b0001, 1, 8'h2F, 1, 1));

        // Reset mid-burst: pending beat dropped, lock and ptr cleared, req0 wins.
        step(200, mk(0, 4'b0010, 4'b0000, 8'h50, 8'h21, 8'h00, 8'h00, 1, 4'b0010, 1, 8'h50, 0, 1));
        step(201, mk(1, 4'b0011, 4'b0011, 8'h50, 8'h21, 8'h00, 8'h00, 1, 4'b0000, 1, 8'h21, 1, 0));
        step(202, mk(0, 4'b0011, 4'b0011, 8'h50, 8'h21, 8'h00, 8'h00, 1, 4'b0001, 0, 8'h00, 0, 0));
        step(203, mk(0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 1, 8'h50, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
